alu_mul_sequencer: RTL
======================

Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-and-add multiplier controller. Owns no adder; it time-shares the 32-bit ALU by driving its a/b/control inputs and capturing its result.
- Produces the low N bits of a*b (wrap mod 2^N; identical for signed and unsigned operands).
- Sits beside the ALU in the execute stage. Decode/issue logic starts it with start and waits for done.

Parameters:
N, 32, operand/product width; only 32 supported, used as a constant
CNT_W, $clog2(N)+1, iteration counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in S_IDLE
a  input  N  multiplicand, captured on accepted start
b  input  N  multiplier, captured on accepted start
busy  output  1  high while a multiply is in progress (S_ITER or S_DONE)
done  output  1  one-cycle pulse, product valid
product  output  N  result; held from done until the next accepted start
alu_a  output  N  ALU operand a
alu_b  output  N  ALU operand b
alu_control  output  alu_control_t  ALU opcode
alu_result  input  N  ALU result (combinational from alu_a/alu_b/alu_control)

Behaviour:
- Reset (async, any state): state=S_IDLE; acc, mcand, mplier, count, product = 0; busy=0, done=0.
- Reset mid-operation abandons the multiply with no done pulse.
- ALU outputs in S_IDLE/S_DONE: alu_a=0, alu_b=0, alu_control=ALU_ADD (benign).
- ALU outputs in S_ITER: alu_a=acc, alu_b=mcand, alu_control=ALU_ADD. The ALU overflow flag is ignored; addition wraps mod 2^N.
- State S_IDLE:
  - If start=1 at the edge: acc<=0, mcand<=a, mplier<=b, count<=0, go to S_ITER.
  - start=0: stay in S_IDLE.
- State S_ITER (one iteration per edge):
  - If mplier[0]=1: acc<=alu_result; otherwise acc is unchanged.
  - mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (logical); count<=count+1.
  - When count==N-1 at the edge (32nd iteration): product<=final acc value (including this iteration's add), go to S_DONE.
- State S_DONE:
  - done=1 for exactly this one cycle; busy=1; go to S_IDLE at the next edge.
  - Any start seen in this cycle is ignored.
- Latency (feature off): done is high in the cycle after the 32nd edge following the start edge, i.e. 33 edges from start to return to S_IDLE.
- start while busy=1: ignored; operands are not recaptured and the result is unaffected.
- start held high continuously: a new multiply is accepted on the first S_IDLE edge after done, giving back-to-back ops every 34 cycles.
- busy and done are registered outputs, decoded from state only.

Optional Feature:
Macro MUL_EARLY_EXIT_EN.
- Defined:
  - In S_IDLE on accepted start with b==0: go directly to S_DONE with product<=0 (done in the cycle after the start edge).
  - In S_ITER: if (mplier>>1)==0 at the edge, that iteration is the last: product<=final acc, go to S_DONE.
  - Iterations = index of the highest set bit of b, plus 1.
- Undefined: always exactly N iterations, regardless of b.
- The product value is identical in both builds; only latency differs.

Test Plan:
- a=7, b=6, start 1 cycle -> done pulses once; product=42. Edges from start to done: 32 (feature off) or 3 (feature on); busy high throughout.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x00000001. Feature on: 32 iterations; overflow ignored.
- a=0x00010000, b=0x00010000 -> product=0x00000000 (wrap). Then a=3, b=0 -> product=0; feature on: done 1 edge after start.
- Start a=5, b=9; at iteration 4 pulse start with a=100, b=100 -> ignored; product=45; exactly one done pulse.
- Start a=12, b=12; assert rst asynchronously mid-iteration, between edges -> busy, done, product drop to 0 immediately; no done pulse. After release, a=2, b=3 -> product=6.
- start held high for 3 ops (2*3, 4*5, 0x80000000*2) -> products 6, 20, 0. Each done is one cycle wide with at least one S_IDLE cycle between ops; alu_control=ALU_ADD whenever in S_ITER.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Shift-and-add multiplier controller that borrows the execute-stage
//            ALU adder; produces the low N bits of a*b. The ALU opcode is a
//            4-bit field and ALU_ADD is encoded as 4'b0010.
// Options  : MUL_EARLY_EXIT_EN - stop iterating once the remaining multiplier
//            bits are zero (same product, shorter latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result
);

    localparam logic [3:0] c_ALU_ADD = 4'b0010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_acc;
    logic [N-1:0]       r_mcand;
    logic [N-1:0]       r_mplier;
    logic [N-1:0]       r_product;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;

    logic [N-1:0]       w_acc_nxt;
    logic               w_last;
    logic               w_zero_b;
    logic [N-1:0]       w_alu_a;
    logic [N-1:0]       w_alu_b;

    // The add result is only kept when the current multiplier bit is set.
    assign w_acc_nxt = r_mplier[0] ? alu_result : r_acc;

`ifdef MUL_EARLY_EXIT_EN
    assign w_last   = (r_count == CNT_W'(N - 1)) || ((r_mplier >> 1) == '0);
    assign w_zero_b = (b == '0);
`else
    assign w_last   = (r_count == CNT_W'(N - 1));
    assign w_zero_b = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_alu_a     = '0;
        w_alu_b     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_b ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                w_alu_a = r_acc;
                w_alu_b = r_mcand;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_count  <= '0;
                        if (w_zero_b) begin
                            r_product <= '0;
                        end
                    end
                end
                S_ITER: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_product <= w_acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign product     = r_product;
    assign alu_a       = w_alu_a;
    assign alu_b       = w_alu_b;
    assign alu_control = c_ALU_ADD;

endmodule

`default_nettype wire
